// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader,
// the PC and the pipeline-register modules.
package imem_loader_pkg;

  // Default instruction-memory geometry: 512 bytes, one byte per write.
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load request, producer byte stream and instruction-memory
// write port, plus the CPU hold / status lines.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W,
  parameter int DATA_W = imem_loader_pkg::IMEM_DATA_W
);
  logic              start;
  logic [ADDR_W:0]   length;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              chk_err;

  // The loader itself.
  modport slave (
    input  start, length, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, chk_err
  );

  // Whoever requests the load and supplies the bytes.
  modport master (
    output start, length, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, chk_err
  );
endinterface

// File: rtl/imem_checksum.sv
// Running modulo-2^W sum of payload bytes, cleared at the start of each load.
module imem_checksum #(
  parameter int W = imem_loader_pkg::IMEM_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] byte_in,
  output logic [W-1:0] sum
);
  logic [W-1:0] sum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (enable) begin
      sum_reg <= sum_reg + byte_in;
    end
  end

  assign sum = sum_reg;
endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a byte payload into instruction memory while holding
// the CPU; define IMEM_LOADER_CHECKSUM_EN to verify a trailing checksum byte.
module imem_loader #(
  parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W,
  parameter int DATA_W = imem_loader_pkg::IMEM_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);
  import imem_loader_pkg::*;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     state_reg;
  loader_state_t     state_next;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   len_clamped;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic byte_ready;
  logic done;
  logic cpu_hold;
  logic chk_err;
  logic start_ok;
  logic accept;
  logic load_accept;
  logic last_byte;

  assign len_clamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
  // A start is only honoured while no load is in flight.
  assign start_ok    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign accept      = bus.byte_valid && byte_ready;
  assign load_accept = accept && (state_reg == LOAD);
  // Counter width is ADDR_W+1, so the compare against 2^ADDR_W never wraps.
  assign last_byte   = load_accept && ((cnt_reg + CNT_ONE) == len_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = (bus.length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_next = DONE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // done waits for the final write strobe to retire, so the CPU is released
  // only after the last byte has actually landed in memory.
  always_comb begin
    byte_ready = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state_reg)
      LOAD: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: byte_ready = 1'b1;
`endif
      DONE: begin
        done     = !mem_we_reg;
        cpu_hold = mem_we_reg || chk_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      len_reg <= '0;
    end else if (start_ok) begin
      cnt_reg <= '0;
      len_reg <= len_clamped;
    end else if (load_accept) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  // Write port: strobe follows acceptance by one cycle; address/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_we_reg <= load_accept;
      if (load_accept) begin
        mem_addr_reg  <= cnt_reg[ADDR_W-1:0];
        mem_wdata_reg <= bus.byte_data;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] chk_total;
  logic              chk_err_reg;

  imem_checksum #(
    .W(DATA_W)
  ) u_checksum (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .enable  (load_accept),
    .byte_in (bus.byte_data),
    .sum     (sum)
  );

  // Payload plus check byte must total zero.
  assign chk_total = sum + bus.byte_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_err_reg <= 1'b0;
    end else if (start_ok) begin
      chk_err_reg <= 1'b0;
    end else if (accept && (state_reg == CHECK)) begin
      chk_err_reg <= (chk_total != '0);
    end
  end

  assign chk_err = chk_err_reg;
`else
  assign chk_err = 1'b0;
`endif

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.done       = done;
  assign bus.chk_err    = chk_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader; the checksum test runs only
// when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = IMEM_ADDR_W;
  localparam int DATA_W = IMEM_DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t               exp_q[$];
  wr_t               mon_exp;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;
  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: every write strobe pops one expected write; idle cycles must hold the bus.
  always @(negedge clk) begin
    if (!reset) begin
      last_addr = '0;
      last_data = '0;
    end
    if (bus.mem_we === 1'b1) begin
      wr_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.mem_addr !== mon_exp.addr || bus.mem_wdata !== mon_exp.data) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   bus.mem_addr, bus.mem_wdata, mon_exp.addr, mon_exp.data);
        end else begin
          $display("[TB] write addr=%0d data=%02h", bus.mem_addr, bus.mem_wdata);
        end
      end
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
    end else if (reset) begin
      tests++;
      if (bus.mem_addr !== last_addr || bus.mem_wdata !== last_data) begin
        fails++;
        $display("FAIL bus_hold: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                 bus.mem_addr, bus.mem_wdata, last_addr, last_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] check %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    bus.start  = 1'b1;
    bus.length = len;
    tick();
    bus.start  = 1'b0;
    $display("[TB] start length=%0d", len);
  endtask

  // Present one byte until accepted; payload bytes also queue their expected write.
  task automatic send_byte(input logic [DATA_W-1:0] d, input bit is_payload, input int addr);
    bit  acc;
    int  budget;
    wr_t w;
    if (is_payload) begin
      w.addr = addr[ADDR_W-1:0];
      w.data = d;
      exp_q.push_back(w);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    acc    = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      @(negedge clk);
      acc = bus.byte_ready;
      tick();
      budget++;
    end
    bus.byte_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: byte_ready stayed 0 for byte %02h, expected 1", d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, bus.byte_ready, 0);
    check({tag, "_mem_we"},     bus.mem_we,     0);
    check({tag, "_mem_addr"},   bus.mem_addr,   0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,  0);
    check({tag, "_cpu_hold"},   bus.cpu_hold,   1);
    check({tag, "_done"},       bus.done,       0);
    check({tag, "_chk_err"},    bus.chk_err,    0);
  endtask

  logic [DATA_W-1:0] t1_bytes [4] = '{8'h24, 8'h02, 8'h00, 8'h05};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int c0;
    logic [DATA_W-1:0] d;

    bus.start = 1'b0;
    bus.length = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;

    #12;
    check_reset_outputs("rst");
    tick();
    reset = 1'b1;
    tick();
    check("idle_ready", bus.byte_ready, 0);
    check("idle_hold", bus.cpu_hold, 1);
    check("idle_done", bus.done, 0);

    // Zero-length load goes straight to DONE with no writes.
    base = wr_count;
    do_start(0);
    check("len0_done", bus.done, 1);
    check("len0_hold", bus.cpu_hold, 0);
    check("len0_ready", bus.byte_ready, 0);
    tick();
    check("len0_writes", wr_count - base, 0);

    // Basic back-to-back load.
    base = wr_count;
    do_start(4);
    check("t1_ready", bus.byte_ready, 1);
    check("t1_hold", bus.cpu_hold, 1);
    check("t1_done_clr", bus.done, 0);
    c0 = cyc;
    for (int i = 0; i < 4; i++) send_byte(t1_bytes[i], 1'b1, i);
    check("t1_no_bubbles", cyc - c0, 4);
    check("t1_ready_drop", bus.byte_ready, 0);
    tick();
    check("t1_done", bus.done, 1);
    check("t1_hold_rel", bus.cpu_hold, 0);
    check("t1_writes", wr_count - base, 4);
    check("t1_q_empty", exp_q.size(), 0);

    // Backpressure: valid toggles 1,0,1,0.
    base = wr_count;
    do_start(2);
    check("t2_hold", bus.cpu_hold, 1);
    send_byte(8'hA1, 1'b1, 0);
    gap(1);
    send_byte(8'hB2, 1'b1, 1);
    gap(1);
    check("t2_writes", wr_count - base, 2);
    check("t2_done", bus.done, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // Start pulsed mid-load must be ignored.
    base = wr_count;
    do_start(4);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 1);
    bus.start  = 1'b1;
    bus.length = 1;
    tick();
    bus.start  = 1'b0;
    check("t6_ready", bus.byte_ready, 1);
    check("t6_done", bus.done, 0);
    send_byte(8'h33, 1'b1, 2);
    send_byte(8'h44, 1'b1, 3);
    tick();
    check("t6_done_end", bus.done, 1);
    check("t6_writes", wr_count - base, 4);
    check("t6_q_empty", exp_q.size(), 0);

    // Reset mid-load after 3 of 8 bytes.
    base = wr_count;
    do_start(8);
    for (int i = 0; i < 3; i++) send_byte(DATA_W'(8'hC0 + i), 1'b1, i);
    gap(1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("t4_rst");
    bus.byte_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t4_idle_ready", bus.byte_ready, 0);
    check("t4_idle_hold", bus.cpu_hold, 1);
    bus.byte_valid = 1'b0;
    check("t4_writes_abort", wr_count - base, 3);
    base = wr_count;
    do_start(8);
    for (int i = 0; i < 8; i++) send_byte(DATA_W'(8'hD0 + i), 1'b1, i);
    tick();
    check("t4_restart_writes", wr_count - base, 8);
    check("t4_done", bus.done, 1);
    check("t4_q_empty", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum: 0x01 + 0x02 + 0xFD = 0x100.
    base = wr_count;
    do_start(2);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'hFD, 1'b0, 0);
    check("t5_good_chk_err", bus.chk_err, 0);
    check("t5_good_hold", bus.cpu_hold, 0);
    check("t5_good_done", bus.done, 1);
    check("t5_good_writes", wr_count - base, 2);
    // Bad checksum leaves the CPU held.
    base = wr_count;
    do_start(2);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h00, 1'b0, 0);
    check("t5_bad_chk_err", bus.chk_err, 1);
    check("t5_bad_hold", bus.cpu_hold, 1);
    check("t5_bad_done", bus.done, 1);
    check("t5_bad_writes", wr_count - base, 2);
    check("t5_q_empty", exp_q.size(), 0);
`endif

    // Oversized length clamps to 512 bytes, last write at 511.
    base = wr_count;
    do_start(600);
    for (int i = 0; i < 512; i++) begin
      d = DATA_W'(i * 7 + 3);
      send_byte(d, 1'b1, i);
    end
    check("t3_ready_drop", bus.byte_ready, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    tick();
    check("t3_writes", wr_count - base, 512);
    check("t3_last_addr", bus.mem_addr, 511);
    check("t3_done", bus.done, 1);
    check("t3_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
